// File: rtl/parking_lot_multi.sv
// parking_lot_multi: LANES entry and exit lane FSMs sharing one capacity-limited occupancy counter.
// Define PARKING_STATS_EN to add saturating EntryCount/ExitCount completion counters.
`timescale 1ns/1ps
module parking_lot_multi #(
   parameter int LANES          = 2,
   parameter int CAPACITY       = 64,
   parameter int TIMEOUT_CYCLES = 16,
   parameter int MAX_RETRY      = 2,
   parameter int GATE_CYCLES    = 4
) (
   input  logic                             clk,
   input  logic                             resetn,
   input  logic [LANES-1:0]                 CarDetectEntry,
   input  logic [LANES-1:0]                 ValidTag1,
   input  logic [LANES-1:0]                 ValidationFail1,
   input  logic [LANES-1:0]                 CarDetectExit,
   input  logic [LANES-1:0]                 ValidTag2,
   input  logic [LANES-1:0]                 ValidationFail2,
   input  logic [LANES-1:0]                 PaymentDone,
   output logic [LANES-1:0]                 ActivateRFID1,
   output logic [LANES-1:0]                 ActivateRFID2,
   output logic [LANES-1:0]                 IssueTicket,
   output logic [LANES-1:0]                 OpenEntryGate,
   output logic [LANES-1:0]                 OpenExitGate,
   output logic [LANES-1:0]                 InitPayment,
   output logic [LANES-1:0]                 AssertError,
   output logic                             LotFull,
   output logic [$clog2(CAPACITY+1)-1:0]    Occupancy,
`ifdef PARKING_STATS_EN
   output logic [15:0]                      EntryCount,
   output logic [15:0]                      ExitCount,
`endif
   output logic [2*LANES-1:0]               dbg_entry_state_o,
   output logic [3*LANES-1:0]               dbg_exit_state_o
);

   localparam int OCC_W   = $clog2(CAPACITY + 1);
   localparam int SUM_W   = OCC_W + 4;
   localparam int CNT_MAX = (TIMEOUT_CYCLES > GATE_CYCLES) ? TIMEOUT_CYCLES : GATE_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam int RTY_W   = $clog2(MAX_RETRY + 1);

   typedef enum logic [1:0] {
      E_IDLE   = 2'd0,
      E_RFID   = 2'd1,
      E_TICKET = 2'd2,
      E_GATE   = 2'd3
   } entry_state_e;

   typedef enum logic [2:0] {
      X_IDLE = 3'd0,
      X_RFID = 3'd1,
      X_PAY  = 3'd2,
      X_GATE = 3'd3,
      X_ERR  = 3'd4
   } exit_state_e;

   entry_state_e     e_state_q [LANES];
   entry_state_e     e_state_d [LANES];
   logic [CNT_W-1:0] e_cnt_q   [LANES];
   logic [CNT_W-1:0] e_cnt_d   [LANES];
   logic [RTY_W-1:0] e_rty_q   [LANES];
   logic [RTY_W-1:0] e_rty_d   [LANES];

   exit_state_e      x_state_q [LANES];
   exit_state_e      x_state_d [LANES];
   logic [CNT_W-1:0] x_cnt_q   [LANES];
   logic [CNT_W-1:0] x_cnt_d   [LANES];
   logic [RTY_W-1:0] x_rty_q   [LANES];
   logic [RTY_W-1:0] x_rty_d   [LANES];

   logic [OCC_W-1:0] occ_q;
   logic [OCC_W-1:0] occ_d;
   logic [SUM_W-1:0] occ_ext;
   logic [SUM_W-1:0] pend_e;
   logic [SUM_W-1:0] pend_x;
   logic [SUM_W-1:0] n_e_done;
   logic [SUM_W-1:0] n_x_done;
   logic             entry_room;
   logic             exit_avail;
   logic [LANES-1:0] e_gnt;
   logic [LANES-1:0] x_gnt;

   // Any lane outside idle holds a reserved slot, so concurrent lanes can never overfill or underflow.
   always_comb begin
      pend_e = '0;
      pend_x = '0;
      for (int i = 0; i < LANES; i++) begin
         pend_e = pend_e + SUM_W'(e_state_q[i] != E_IDLE);
         pend_x = pend_x + SUM_W'(x_state_q[i] != X_IDLE);
      end
   end

   assign occ_ext    = SUM_W'(occ_q);
   assign entry_room = (occ_ext + pend_e) < SUM_W'(CAPACITY);
   assign exit_avail = occ_ext > pend_x;
   assign LotFull    = (occ_ext + pend_e) == SUM_W'(CAPACITY);
   assign Occupancy  = occ_q;

   // Request/grant: an idle lane with a car present requests; the grant is consumed on the edge it is issued.
   always_comb begin
      e_gnt = '0;
      x_gnt = '0;
      for (int i = LANES - 1; i >= 0; i--) begin
         if ((e_state_q[i] == E_IDLE) && CarDetectEntry[i] && entry_room) begin
            e_gnt    = '0;
            e_gnt[i] = 1'b1;
         end
         if ((x_state_q[i] == X_IDLE) && CarDetectExit[i] && exit_avail) begin
            x_gnt    = '0;
            x_gnt[i] = 1'b1;
         end
      end
   end

   always_comb begin
      n_e_done = '0;
      for (int i = 0; i < LANES; i++) begin
         e_state_d[i] = e_state_q[i];
         e_cnt_d[i]   = e_cnt_q[i];
         e_rty_d[i]   = e_rty_q[i];
         case (e_state_q[i])
            E_IDLE: begin
               if (e_gnt[i]) begin
                  e_state_d[i] = E_RFID;
                  e_cnt_d[i]   = '0;
                  e_rty_d[i]   = '0;
               end
            end
            E_RFID: begin
               if (ValidTag1[i]) begin
                  e_state_d[i] = E_GATE;
                  e_cnt_d[i]   = '0;
               end else if (ValidationFail1[i]) begin
                  e_cnt_d[i] = '0;
                  if (e_rty_q[i] == RTY_W'(MAX_RETRY - 1)) begin
                     e_state_d[i] = E_TICKET;
                  end else begin
                     e_rty_d[i] = e_rty_q[i] + RTY_W'(1);
                  end
               end else if (e_cnt_q[i] == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                  e_state_d[i] = E_TICKET;
               end else begin
                  e_cnt_d[i] = e_cnt_q[i] + CNT_W'(1);
               end
            end
            E_TICKET: begin
               e_state_d[i] = E_GATE;
               e_cnt_d[i]   = '0;
            end
            E_GATE: begin
               if (e_cnt_q[i] == CNT_W'(GATE_CYCLES - 1)) begin
                  e_state_d[i] = E_IDLE;
                  n_e_done     = n_e_done + SUM_W'(1);
               end else begin
                  e_cnt_d[i] = e_cnt_q[i] + CNT_W'(1);
               end
            end
            default: e_state_d[i] = E_IDLE;
         endcase
      end
   end

   always_comb begin
      n_x_done = '0;
      for (int i = 0; i < LANES; i++) begin
         x_state_d[i] = x_state_q[i];
         x_cnt_d[i]   = x_cnt_q[i];
         x_rty_d[i]   = x_rty_q[i];
         case (x_state_q[i])
            X_IDLE: begin
               if (x_gnt[i]) begin
                  x_state_d[i] = X_RFID;
                  x_cnt_d[i]   = '0;
                  x_rty_d[i]   = '0;
               end
            end
            X_RFID: begin
               if (ValidTag2[i]) begin
                  x_state_d[i] = X_GATE;
                  x_cnt_d[i]   = '0;
               end else if (ValidationFail2[i]) begin
                  x_cnt_d[i] = '0;
                  if (x_rty_q[i] == RTY_W'(MAX_RETRY - 1)) begin
                     x_state_d[i] = X_PAY;
                  end else begin
                     x_rty_d[i] = x_rty_q[i] + RTY_W'(1);
                  end
               end else if (x_cnt_q[i] == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                  x_state_d[i] = X_PAY;
                  x_cnt_d[i]   = '0;
               end else begin
                  x_cnt_d[i] = x_cnt_q[i] + CNT_W'(1);
               end
            end
            X_PAY: begin
               if (PaymentDone[i]) begin
                  x_state_d[i] = X_GATE;
                  x_cnt_d[i]   = '0;
               end else if (x_cnt_q[i] == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                  x_state_d[i] = X_ERR;
               end else begin
                  x_cnt_d[i] = x_cnt_q[i] + CNT_W'(1);
               end
            end
            X_GATE: begin
               if (x_cnt_q[i] == CNT_W'(GATE_CYCLES - 1)) begin
                  x_state_d[i] = X_IDLE;
                  n_x_done     = n_x_done + SUM_W'(1);
               end else begin
                  x_cnt_d[i] = x_cnt_q[i] + CNT_W'(1);
               end
            end
            X_ERR: begin
               if (!CarDetectExit[i]) x_state_d[i] = X_IDLE;
            end
            default: x_state_d[i] = X_IDLE;
         endcase
      end
   end

   assign occ_d = OCC_W'(occ_ext + n_e_done - n_x_done);

   always_ff @(posedge clk) begin
      if (!resetn) begin
         for (int i = 0; i < LANES; i++) begin
            e_state_q[i] <= E_IDLE;
            e_cnt_q[i]   <= '0;
            e_rty_q[i]   <= '0;
            x_state_q[i] <= X_IDLE;
            x_cnt_q[i]   <= '0;
            x_rty_q[i]   <= '0;
         end
         occ_q <= '0;
      end else begin
         for (int i = 0; i < LANES; i++) begin
            e_state_q[i] <= e_state_d[i];
            e_cnt_q[i]   <= e_cnt_d[i];
            e_rty_q[i]   <= e_rty_d[i];
            x_state_q[i] <= x_state_d[i];
            x_cnt_q[i]   <= x_cnt_d[i];
            x_rty_q[i]   <= x_rty_d[i];
         end
         occ_q <= occ_d;
      end
   end

   always_comb begin
      ActivateRFID1     = '0;
      ActivateRFID2     = '0;
      IssueTicket       = '0;
      OpenEntryGate     = '0;
      OpenExitGate      = '0;
      InitPayment       = '0;
      AssertError       = '0;
      dbg_entry_state_o = '0;
      dbg_exit_state_o  = '0;
      for (int i = 0; i < LANES; i++) begin
         ActivateRFID1[i] = (e_state_q[i] == E_RFID);
         IssueTicket[i]   = (e_state_q[i] == E_TICKET);
         OpenEntryGate[i] = (e_state_q[i] == E_GATE);
         ActivateRFID2[i] = (x_state_q[i] == X_RFID);
         InitPayment[i]   = (x_state_q[i] == X_PAY);
         OpenExitGate[i]  = (x_state_q[i] == X_GATE);
         AssertError[i]   = (x_state_q[i] == X_ERR);
         dbg_entry_state_o[2*i +: 2] = e_state_q[i];
         dbg_exit_state_o[3*i +: 3]  = x_state_q[i];
      end
   end

`ifdef PARKING_STATS_EN
   logic [16:0] ent_sum;
   logic [16:0] ext_sum;
   logic [15:0] ent_cnt_q;
   logic [15:0] ent_cnt_d;
   logic [15:0] ext_cnt_q;
   logic [15:0] ext_cnt_d;

   // Counters stick at 0xFFFF rather than wrapping.
   always_comb begin
      ent_sum   = {1'b0, ent_cnt_q} + 17'(n_e_done);
      ext_sum   = {1'b0, ext_cnt_q} + 17'(n_x_done);
      ent_cnt_d = ent_sum[16] ? 16'hFFFF : ent_sum[15:0];
      ext_cnt_d = ext_sum[16] ? 16'hFFFF : ext_sum[15:0];
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         ent_cnt_q <= '0;
         ext_cnt_q <= '0;
      end else begin
         ent_cnt_q <= ent_cnt_d;
         ext_cnt_q <= ext_cnt_d;
      end
   end

   assign EntryCount = ent_cnt_q;
   assign ExitCount  = ext_cnt_q;
`endif

endmodule

// File: tb/tb_parking_lot_multi.sv
// Directed bench for parking_lot_multi (LANES=2, CAPACITY=2, TIMEOUT_CYCLES=8, MAX_RETRY=2, GATE_CYCLES=3).
`timescale 1ns/1ps
module tb_parking_lot_multi;

   logic       clk = 1'b0;
   logic       resetn;
   logic [1:0] CarDetectEntry, ValidTag1, ValidationFail1;
   logic [1:0] CarDetectExit, ValidTag2, ValidationFail2, PaymentDone;
   logic [1:0] ActivateRFID1, ActivateRFID2, IssueTicket, OpenEntryGate, OpenExitGate;
   logic [1:0] InitPayment, AssertError;
   logic       LotFull;
   logic [1:0] Occupancy;
   logic [3:0] dbg_entry_state;
   logic [5:0] dbg_exit_state;
`ifdef PARKING_STATS_EN
   logic [15:0] entry_count, exit_count;
`endif

   int checks = 0;
   int failures = 0;
   int exp_entries = 0;
   int exp_exits = 0;
   logic [1:0] exp_q[$];

   parking_lot_multi #(
      .LANES(2), .CAPACITY(2), .TIMEOUT_CYCLES(8), .MAX_RETRY(2), .GATE_CYCLES(3)
   ) dut (
      .clk(clk), .resetn(resetn),
      .CarDetectEntry(CarDetectEntry), .ValidTag1(ValidTag1), .ValidationFail1(ValidationFail1),
      .CarDetectExit(CarDetectExit), .ValidTag2(ValidTag2), .ValidationFail2(ValidationFail2),
      .PaymentDone(PaymentDone),
      .ActivateRFID1(ActivateRFID1), .ActivateRFID2(ActivateRFID2), .IssueTicket(IssueTicket),
      .OpenEntryGate(OpenEntryGate), .OpenExitGate(OpenExitGate), .InitPayment(InitPayment),
      .AssertError(AssertError), .LotFull(LotFull), .Occupancy(Occupancy),
`ifdef PARKING_STATS_EN
      .EntryCount(entry_count), .ExitCount(exit_count),
`endif
      .dbg_entry_state_o(dbg_entry_state), .dbg_exit_state_o(dbg_exit_state)
   );

   // Clock / reset
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      CarDetectEntry = '0; ValidTag1 = '0; ValidationFail1 = '0;
      CarDetectExit = '0; ValidTag2 = '0; ValidationFail2 = '0; PaymentDone = '0;
   endtask

   // Steps until the selected gate drops; n counts gate-high cycles including the current one.
   task automatic wait_gate(input bit is_entry, input int lane, output int n);
      bit done = 1'b0;
      n = 1;
      for (int k = 0; k < 20; k++) begin
         if (!done) begin
            step();
            if ((is_entry ? OpenEntryGate[lane] : OpenExitGate[lane]) === 1'b1) n++;
            else done = 1'b1;
         end
      end
      if (!done) n = 99;
   endtask

   task automatic test_reset();
      clear_inputs();
      resetn = 1'b0;
      step(); step();
      checks++; if ({ActivateRFID1, ActivateRFID2, IssueTicket, OpenEntryGate, OpenExitGate, InitPayment, AssertError} !== 14'd0) begin failures++; $display("FAIL reset_outputs actual=%b required=0", {ActivateRFID1, ActivateRFID2, IssueTicket, OpenEntryGate, OpenExitGate, InitPayment, AssertError}); end
      checks++; if (Occupancy !== 2'd0) begin failures++; $display("FAIL reset_occupancy actual=%0d required=0", Occupancy); end
      checks++; if (LotFull !== 1'b0) begin failures++; $display("FAIL reset_lotfull actual=%b required=0", LotFull); end
      checks++; if ({dbg_entry_state, dbg_exit_state} !== 10'd0) begin failures++; $display("FAIL reset_states actual=%b required=0", {dbg_entry_state, dbg_exit_state}); end
      resetn = 1'b1;
      step();
   endtask

   task automatic test_entry_tag();
      int n;
      CarDetectEntry = 2'b01; step(); CarDetectEntry = 2'b00;
      checks++; if (ActivateRFID1 !== 2'b01) begin failures++; $display("FAIL tag_rfid_on actual=%b required=01", ActivateRFID1); end
      step();
      ValidTag1 = 2'b01; step(); ValidTag1 = 2'b00;
      checks++; if (OpenEntryGate !== 2'b01) begin failures++; $display("FAIL tag_gate_open actual=%b required=01", OpenEntryGate); end
      checks++; if (ActivateRFID1 !== 2'b00) begin failures++; $display("FAIL tag_rfid_off actual=%b required=00", ActivateRFID1); end
      checks++; if (Occupancy !== 2'd0) begin failures++; $display("FAIL tag_occ_during_gate actual=%0d required=0", Occupancy); end
      wait_gate(1'b1, 0, n);
      exp_entries++;
      checks++; if (n !== 3) begin failures++; $display("FAIL tag_gate_len actual=%0d required=3", n); end
      checks++; if (Occupancy !== 2'd1) begin failures++; $display("FAIL tag_occ_after actual=%0d required=1", Occupancy); end
   endtask

   task automatic test_retry_fallback();
      int n;
      CarDetectEntry = 2'b01; step(); CarDetectEntry = 2'b00;
      checks++; if (ActivateRFID1 !== 2'b01) begin failures++; $display("FAIL retry_rfid_on actual=%b required=01", ActivateRFID1); end
      checks++; if (LotFull !== 1'b1) begin failures++; $display("FAIL retry_lotfull_pending actual=%b required=1", LotFull); end
      ValidationFail1 = 2'b01; step(); ValidationFail1 = 2'b00; step();
      checks++; if ({ActivateRFID1, IssueTicket} !== 4'b0100) begin failures++; $display("FAIL retry_after_first_fail actual=%b required=0100", {ActivateRFID1, IssueTicket}); end
      ValidationFail1 = 2'b01; step(); ValidationFail1 = 2'b00;
      checks++; if ({IssueTicket, OpenEntryGate} !== 4'b0100) begin failures++; $display("FAIL retry_ticket actual=%b required=0100", {IssueTicket, OpenEntryGate}); end
      step();
      checks++; if ({IssueTicket, OpenEntryGate} !== 4'b0001) begin failures++; $display("FAIL retry_ticket_to_gate actual=%b required=0001", {IssueTicket, OpenEntryGate}); end
      wait_gate(1'b1, 0, n);
      exp_entries++;
      checks++; if (n !== 3) begin failures++; $display("FAIL retry_gate_len actual=%0d required=3", n); end
      checks++; if (Occupancy !== 2'd2) begin failures++; $display("FAIL retry_occ actual=%0d required=2", Occupancy); end
      CarDetectEntry = 2'b01; step(); step();
      checks++; if ({ActivateRFID1, LotFull} !== 3'b001) begin failures++; $display("FAIL full_no_grant actual=%b required=001", {ActivateRFID1, LotFull}); end
      CarDetectEntry = 2'b00;
   endtask

   task automatic test_exit_payment();
      int n;
      CarDetectExit = 2'b01; step(); CarDetectExit = 2'b00;
      checks++; if (ActivateRFID2 !== 2'b01) begin failures++; $display("FAIL pay_rfid_on actual=%b required=01", ActivateRFID2); end
      ValidationFail2 = 2'b01; step(); ValidationFail2 = 2'b00; step();
      ValidationFail2 = 2'b01; step(); ValidationFail2 = 2'b00;
      checks++; if ({InitPayment, ActivateRFID2} !== 4'b0100) begin failures++; $display("FAIL pay_init actual=%b required=0100", {InitPayment, ActivateRFID2}); end
      step(); step();
      PaymentDone = 2'b01; step(); PaymentDone = 2'b00;
      checks++; if ({OpenExitGate, InitPayment} !== 4'b0100) begin failures++; $display("FAIL pay_gate_open actual=%b required=0100", {OpenExitGate, InitPayment}); end
      wait_gate(1'b0, 0, n);
      exp_exits++;
      checks++; if (n !== 3) begin failures++; $display("FAIL pay_gate_len actual=%0d required=3", n); end
      checks++; if (Occupancy !== 2'd1) begin failures++; $display("FAIL pay_occ actual=%0d required=1", Occupancy); end
   endtask

   task automatic test_concurrency();
      int n;
      CarDetectEntry = 2'b11; step();
      checks++; if ({ActivateRFID1, LotFull} !== 3'b011) begin failures++; $display("FAIL conc_one_grant actual=%b required=011", {ActivateRFID1, LotFull}); end
      CarDetectEntry = 2'b10;
      ValidTag1 = 2'b01; step(); ValidTag1 = 2'b00;
      checks++; if ({ActivateRFID1, OpenEntryGate} !== 4'b0001) begin failures++; $display("FAIL conc_lane1_waits actual=%b required=0001", {ActivateRFID1, OpenEntryGate}); end
      wait_gate(1'b1, 0, n);
      exp_entries++;
      checks++; if ({Occupancy, ActivateRFID1, LotFull} !== 5'b10001) begin failures++; $display("FAIL conc_full_idle actual=%b required=10001", {Occupancy, ActivateRFID1, LotFull}); end
      CarDetectExit = 2'b01; step(); CarDetectExit = 2'b00;
      checks++; if ({ActivateRFID2, ActivateRFID1} !== 4'b0100) begin failures++; $display("FAIL conc_exit_grant actual=%b required=0100", {ActivateRFID2, ActivateRFID1}); end
      ValidTag2 = 2'b01; step(); ValidTag2 = 2'b00;
      wait_gate(1'b0, 0, n);
      exp_exits++;
      checks++; if ({Occupancy, ActivateRFID1, LotFull} !== 5'b01000) begin failures++; $display("FAIL conc_after_exit actual=%b required=01000", {Occupancy, ActivateRFID1, LotFull}); end
      step();
      checks++; if ({ActivateRFID1, LotFull} !== 3'b101) begin failures++; $display("FAIL conc_lane1_granted actual=%b required=101", {ActivateRFID1, LotFull}); end
      CarDetectEntry = 2'b00;
   endtask

   task automatic test_simultaneous();
      logic [1:0] e;
      CarDetectExit = 2'b01; step(); CarDetectExit = 2'b00;
      checks++; if (ActivateRFID2 !== 2'b01) begin failures++; $display("FAIL sim_exit_grant actual=%b required=01", ActivateRFID2); end
      ValidTag1 = 2'b10; ValidTag2 = 2'b01; step(); ValidTag1 = 2'b00; ValidTag2 = 2'b00;
      checks++; if ({OpenEntryGate, OpenExitGate} !== 4'b1001) begin failures++; $display("FAIL sim_gates_open actual=%b required=1001", {OpenEntryGate, OpenExitGate}); end
      exp_q.push_back(2'd1); exp_q.push_back(2'd1); exp_q.push_back(2'd1);
      while (exp_q.size() > 0) begin
         step();
         e = exp_q.pop_front();
         checks++; if (Occupancy !== e) begin failures++; $display("FAIL sim_occ actual=%0d required=%0d", Occupancy, e); end
      end
      exp_entries++; exp_exits++;
      checks++; if ({OpenEntryGate, OpenExitGate} !== 4'b0000) begin failures++; $display("FAIL sim_gates_closed actual=%b required=0000", {OpenEntryGate, OpenExitGate}); end
`ifdef PARKING_STATS_EN
      checks++; if (entry_count !== 16'(exp_entries)) begin failures++; $display("FAIL sim_entry_count actual=%0d required=%0d", entry_count, exp_entries); end
      checks++; if (exit_count !== 16'(exp_exits)) begin failures++; $display("FAIL sim_exit_count actual=%0d required=%0d", exit_count, exp_exits); end
`endif
   endtask

   task automatic test_entry_timeout();
      int k = 0;
      int n;
      CarDetectEntry = 2'b01; step(); CarDetectEntry = 2'b00;
      checks++; if (ActivateRFID1 !== 2'b01) begin failures++; $display("FAIL tmo_rfid_on actual=%b required=01", ActivateRFID1); end
      for (int c = 1; c <= 20; c++) begin
         if (k == 0) begin
            step();
            if (IssueTicket[0] === 1'b1) k = c;
         end
      end
      checks++; if (k !== 8) begin failures++; $display("FAIL tmo_ticket_latency actual=%0d required=8", k); end
      step();
      checks++; if ({IssueTicket, OpenEntryGate} !== 4'b0001) begin failures++; $display("FAIL tmo_gate actual=%b required=0001", {IssueTicket, OpenEntryGate}); end
      wait_gate(1'b1, 0, n);
      exp_entries++;
      checks++; if (Occupancy !== 2'd2) begin failures++; $display("FAIL tmo_occ actual=%0d required=2", Occupancy); end
   endtask

   task automatic test_exit_error();
      int k = 0;
      CarDetectExit = 2'b01; step();
      checks++; if (ActivateRFID2 !== 2'b01) begin failures++; $display("FAIL err_rfid_on actual=%b required=01", ActivateRFID2); end
      ValidationFail2 = 2'b01; step(); ValidationFail2 = 2'b00; step();
      ValidationFail2 = 2'b01; step(); ValidationFail2 = 2'b00;
      checks++; if (InitPayment !== 2'b01) begin failures++; $display("FAIL err_init_pay actual=%b required=01", InitPayment); end
      for (int c = 1; c <= 20; c++) begin
         if (k == 0) begin
            step();
            if (AssertError[0] === 1'b1) k = c;
         end
      end
      checks++; if (k !== 8) begin failures++; $display("FAIL err_latency actual=%0d required=8", k); end
      step(); step(); step();
      checks++; if ({AssertError, InitPayment} !== 4'b0100) begin failures++; $display("FAIL err_held actual=%b required=0100", {AssertError, InitPayment}); end
      CarDetectExit = 2'b00; step();
      checks++; if ({AssertError, ActivateRFID2, Occupancy} !== 6'b000010) begin failures++; $display("FAIL err_release actual=%b required=000010", {AssertError, ActivateRFID2, Occupancy}); end
   endtask

   task automatic test_double_exit();
      int n;
      CarDetectExit = 2'b11; step();
      checks++; if (ActivateRFID2 !== 2'b01) begin failures++; $display("FAIL dbl_first_grant actual=%b required=01", ActivateRFID2); end
      step();
      checks++; if (ActivateRFID2 !== 2'b11) begin failures++; $display("FAIL dbl_second_grant actual=%b required=11", ActivateRFID2); end
      CarDetectExit = 2'b00;
      ValidTag2 = 2'b11; step(); ValidTag2 = 2'b00;
      checks++; if (OpenExitGate !== 2'b11) begin failures++; $display("FAIL dbl_gates actual=%b required=11", OpenExitGate); end
      wait_gate(1'b0, 1, n);
      exp_exits += 2;
      checks++; if ({Occupancy, OpenExitGate} !== 4'b0000) begin failures++; $display("FAIL dbl_occ actual=%b required=0000", {Occupancy, OpenExitGate}); end
`ifdef PARKING_STATS_EN
      checks++; if (entry_count !== 16'(exp_entries)) begin failures++; $display("FAIL dbl_entry_count actual=%0d required=%0d", entry_count, exp_entries); end
      checks++; if (exit_count !== 16'(exp_exits)) begin failures++; $display("FAIL dbl_exit_count actual=%0d required=%0d", exit_count, exp_exits); end
`endif
   endtask

   task automatic test_phantom_exit();
      CarDetectExit = 2'b01;
      step(); step(); step();
      checks++; if ({ActivateRFID2, OpenExitGate, Occupancy} !== 6'b000000) begin failures++; $display("FAIL phantom_no_grant actual=%b required=000000", {ActivateRFID2, OpenExitGate, Occupancy}); end
      CarDetectExit = 2'b00;
      step();
   endtask

   task automatic test_reset_mid_gate();
      int n;
      CarDetectEntry = 2'b01; step(); CarDetectEntry = 2'b00;
      ValidTag1 = 2'b01; step(); ValidTag1 = 2'b00;
      wait_gate(1'b1, 0, n);
      checks++; if (Occupancy !== 2'd1) begin failures++; $display("FAIL rmg_occ_before actual=%0d required=1", Occupancy); end
      CarDetectEntry = 2'b01; step(); CarDetectEntry = 2'b00;
      ValidTag1 = 2'b01; step(); ValidTag1 = 2'b00;
      step();
      checks++; if (OpenEntryGate !== 2'b01) begin failures++; $display("FAIL rmg_second_gate_cycle actual=%b required=01", OpenEntryGate); end
      resetn = 1'b0; step();
      checks++; if ({ActivateRFID1, ActivateRFID2, IssueTicket, OpenEntryGate, OpenExitGate, InitPayment, AssertError} !== 14'd0) begin failures++; $display("FAIL rmg_outputs actual=%b required=0", {ActivateRFID1, ActivateRFID2, IssueTicket, OpenEntryGate, OpenExitGate, InitPayment, AssertError}); end
      checks++; if ({Occupancy, LotFull} !== 3'b000) begin failures++; $display("FAIL rmg_occ_lotfull actual=%b required=000", {Occupancy, LotFull}); end
`ifdef PARKING_STATS_EN
      checks++; if ({entry_count, exit_count} !== 32'd0) begin failures++; $display("FAIL rmg_stats actual=%h required=0", {entry_count, exit_count}); end
`endif
      resetn = 1'b1; step();
   endtask

   initial begin
      test_reset();
      test_entry_tag();
      test_retry_fallback();
      test_exit_payment();
      test_concurrency();
      test_simultaneous();
      test_entry_timeout();
      test_exit_error();
      test_double_exit();
      test_phantom_exit();
      test_reset_mid_gate();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      failures++;
      $display("FAIL watchdog actual=timeout required=completion");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog expired");
   end

endmodule
